// File: rtl/paddle_control.sv
// paddle_control: button synchronisers and debouncers, a free-running movement tick, and both paddle positions.
// Optional AUTO_TRACK_EN: the right paddle follows ball_y instead of its buttons.
module paddle_control #(
  parameter int DIV_BIT    = 17,
  parameter int DEB_CYCLES = 50000,
  parameter int STEP       = 2,
  parameter int Y_MIN      = 10,
  parameter int Y_MAX      = 370,
  parameter int INIT_Y     = 190
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up_i,
  input  logic       btn_dn_i,
  input  logic       btn_up_d,
  input  logic       btn_dn_d,
  input  logic       freeze,
`ifdef AUTO_TRACK_EN
  input  logic [9:0] ball_y,
`endif
  output logic [9:0] posbarraiy,
  output logic [9:0] posbarrady,
  output logic       tick
);

  localparam logic [9:0]  STEP_W   = 10'(STEP);
  localparam logic [9:0]  Y_MIN_W  = 10'(Y_MIN);
  localparam logic [9:0]  Y_MAX_W  = 10'(Y_MAX);
  localparam logic [9:0]  INIT_W   = 10'(INIT_Y);
  localparam logic [15:0] DEB_LAST = 16'(DEB_CYCLES - 1);

`ifdef AUTO_TRACK_EN
  localparam int NBTN = 2;
  logic [NBTN-1:0] w_btnRaw;
  assign w_btnRaw = {btn_dn_i, btn_up_i};
`else
  localparam int NBTN = 4;
  logic [NBTN-1:0] w_btnRaw;
  assign w_btnRaw = {btn_dn_d, btn_up_d, btn_dn_i, btn_up_i};
`endif

  logic [NBTN-1:0]    r_sync1;
  logic [NBTN-1:0]    r_sync2;
  logic [NBTN-1:0]    w_lvl;
  logic [DIV_BIT-1:0] r_div;
  logic               r_tick;
  logic [9:0]         r_posL;
  logic [9:0]         r_posR;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_btnRaw;
      r_sync2 <= r_sync1;
    end
  end

  // The debounced level only follows the synced level after DEB_CYCLES consecutive disagreeing cycles.
  for (genvar g = 0; g < NBTN; g++) begin : g_deb
    logic [15:0] r_debCnt;
    logic        r_debLvl;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_debCnt <= '0;
        r_debLvl <= 1'b0;
      end else if (r_sync2[g] == r_debLvl) begin
        r_debCnt <= '0;
      end else if (r_debCnt == DEB_LAST) begin
        r_debLvl <= r_sync2[g];
        r_debCnt <= '0;
      end else begin
        r_debCnt <= r_debCnt + 16'd1;
      end
    end

    assign w_lvl[g] = r_debLvl;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_div  <= r_div + DIV_BIT'(1);
      r_tick <= &r_div;
    end
  end

  function automatic logic [9:0] stepPos(input logic [9:0] pos, input logic up, input logic dn);
    logic [9:0] res;
    res = pos;
    if (up && !dn) begin
      res = (pos >= Y_MIN_W + STEP_W) ? pos - STEP_W : Y_MIN_W;
    end else if (dn && !up) begin
      res = (pos <= Y_MAX_W - STEP_W) ? pos + STEP_W : Y_MAX_W;
    end
    return res;
  endfunction

`ifdef AUTO_TRACK_EN
  // Aim the paddle top 50 px above the ball, landing exactly when within one step.
  function automatic logic [9:0] trackPos(input logic [9:0] pos, input logic [9:0] ball);
    logic [9:0] tgt;
    logic [9:0] res;
    if (ball < Y_MIN_W + 10'd50) begin
      tgt = Y_MIN_W;
    end else if (ball - 10'd50 > Y_MAX_W) begin
      tgt = Y_MAX_W;
    end else begin
      tgt = ball - 10'd50;
    end
    res = pos;
    if (pos < tgt) begin
      res = (tgt - pos <= STEP_W) ? tgt : pos + STEP_W;
    end else if (pos > tgt) begin
      res = (pos - tgt <= STEP_W) ? tgt : pos - STEP_W;
    end
    return res;
  endfunction
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_posL <= INIT_W;
      r_posR <= INIT_W;
    end else if (r_tick && !freeze) begin
      r_posL <= stepPos(r_posL, w_lvl[0], w_lvl[1]);
`ifdef AUTO_TRACK_EN
      r_posR <= trackPos(r_posR, ball_y);
`else
      r_posR <= stepPos(r_posR, w_lvl[2], w_lvl[3]);
`endif
    end
  end

  assign posbarraiy = r_posL;
  assign posbarrady = r_posR;
  assign tick       = r_tick;

endmodule

// File: tb/tb_paddle_control.sv
// Bench for paddle_control with a 16-cycle tick and 4-cycle debounce; table vectors plus a random run
// checked against a history-window reference model.
module tb_paddle_control;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_up_i = 1'b0;
  logic       btn_dn_i = 1'b0;
  logic       btn_up_d = 1'b0;
  logic       btn_dn_d = 1'b0;
  logic       freeze = 1'b0;
  logic [9:0] ballY = 10'd240;
  logic [9:0] posbarraiy;
  logic [9:0] posbarrady;
  logic       tick;

  int total = 0;
  int bad = 0;

  paddle_control #(.DIV_BIT(4), .DEB_CYCLES(4)) dut (
    .clk(clk),
    .rst(rst),
    .btn_up_i(btn_up_i),
    .btn_dn_i(btn_dn_i),
    .btn_up_d(btn_up_d),
    .btn_dn_d(btn_dn_d),
    .freeze(freeze),
`ifdef AUTO_TRACK_EN
    .ball_y(ballY),
`endif
    .posbarraiy(posbarraiy),
    .posbarrady(posbarrady),
    .tick(tick)
  );

  always #5 clk = ~clk;

  // Reference state: raw history gives the 2-cycle synchroniser lag, a 4-deep window gives the debounce.
  int         n = 0;
  logic [3:0] rawHist0 = '0;
  logic [3:0] rawHist1 = '0;
  logic [3:0] seenWin [4] = '{default: '0};
  logic [3:0] mLvl = '0;
  int         mL = 190;
  int         mR = 190;
  logic       mTick = 1'b0;

  function automatic int clampInt(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  task automatic modelEdge();
    logic [3:0] raw;
    logic [3:0] seenNow;
    logic       stable;
    raw = {btn_dn_d, btn_up_d, btn_dn_i, btn_up_i};
    if (rst) begin
      n = 0;
      rawHist0 = '0;
      rawHist1 = '0;
      for (int k = 0; k < 4; k++) seenWin[k] = '0;
      mLvl = '0;
      mL = 190;
      mR = 190;
      mTick = 1'b0;
    end else begin
      seenNow = rawHist1;
      rawHist1 = rawHist0;
      rawHist0 = raw;
      for (int k = 3; k > 0; k--) seenWin[k] = seenWin[k-1];
      seenWin[0] = seenNow;
      if (mTick && !freeze) begin
        mL = clampInt(mL + (mLvl[1] ? 2 : 0) - (mLvl[0] ? 2 : 0), 10, 370);
`ifdef AUTO_TRACK_EN
        mR = mR + clampInt(clampInt(int'(ballY) - 50, 10, 370) - mR, -2, 2);
`else
        mR = clampInt(mR + (mLvl[3] ? 2 : 0) - (mLvl[2] ? 2 : 0), 10, 370);
`endif
      end
      for (int b = 0; b < 4; b++) begin
        stable = 1'b1;
        for (int k = 0; k < 4; k++) if (seenWin[k][b] == mLvl[b]) stable = 1'b0;
        if (stable) mLvl[b] = ~mLvl[b];
      end
      n++;
      mTick = (n % 16 == 0);
    end
  endtask

  task automatic step();
    @(posedge clk);
    modelEdge();
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic upI, input logic dnI, input logic upD,
                               input logic dnD, input logic frz);
    btn_up_i = upI;
    btn_dn_i = dnI;
    btn_up_d = upD;
    btn_dn_d = dnD;
    freeze   = frz;
  endtask

  task automatic checkOutput(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic doReset(input int cycles);
    rst = 1'b1;
    repeat (cycles) step();
    rst = 1'b0;
  endtask

  typedef struct {
    logic upI, dnI, upD, dnD, frz;
    int   cycles;
    int   expL;
    int   expR;
    int   expTicks;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int tickCount;
    int expR;
    int sel;

    // Hand-derived vectors; edge numbers count from the last reset edge.
    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0,   16, 188, 190,   1};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0,   16, 186, 190,   1};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0,   80, 186, 200,   5};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1440, 186, 370,  90};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3200, 370,  10, 200};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1,   80, 370,  10,   5};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0,   16, 368,  10,   1};

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    doReset(2);
    checkOutput("resetL", posbarraiy, 190);
    checkOutput("resetR", posbarrady, 190);
    checkOutput("resetTick", tick, 0);

    for (int k = 1; k <= 15; k++) begin
      step();
      checkOutput("noEarlyTick", tick, 0);
    end
    step();
    checkOutput("firstTick", tick, 1);
    step();
    checkOutput("tickOneCycle", tick, 0);

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) step();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (64) step();
    checkOutput("glitchL", posbarraiy, 190);
    checkOutput("glitchR", posbarrady, 190);

    for (int v = 0; v < 7; v++) begin
      applyStimulus(vecs[v].upI, vecs[v].dnI, vecs[v].upD, vecs[v].dnD, vecs[v].frz);
      tickCount = 0;
      for (int c = 0; c < vecs[v].cycles; c++) begin
        step();
        if (tick) tickCount++;
      end
`ifdef AUTO_TRACK_EN
      expR = 190;
`else
      expR = vecs[v].expR;
`endif
      checkOutput($sformatf("vec%0dL", v), posbarraiy, vecs[v].expL);
      checkOutput($sformatf("vec%0dR", v), posbarrady, expR);
      checkOutput($sformatf("vec%0dTicks", v), tickCount, vecs[v].expTicks);
    end

`ifdef AUTO_TRACK_EN
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    doReset(2);
    ballY = 10'd300;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (640) step();
    checkOutput("trackUpR", posbarrady, 250);
    checkOutput("trackUpL", posbarraiy, 190);
    ballY = 10'd20;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (2080) step();
    checkOutput("trackDownR", posbarrady, 10);
`endif

    // Random run with occasional mid-operation resets, compared cycle by cycle with the model.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) begin
        sel = int'($urandom_range(0, 3));
        case (sel)
          0: btn_up_i = ~btn_up_i;
          1: btn_dn_i = ~btn_dn_i;
          2: btn_up_d = ~btn_up_d;
          default: btn_dn_d = ~btn_dn_d;
        endcase
      end
      if ($urandom_range(0, 63) == 0) freeze = ~freeze;
      if ($urandom_range(0, 99) == 0) ballY = 10'($urandom_range(0, 479));
      rst = ($urandom_range(0, 499) == 0);
      step();
      checkOutput("randL", posbarraiy, mL);
      checkOutput("randR", posbarrady, mR);
      checkOutput("randTick", tick, int'(mTick));
    end
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
